// File: rtl/axi_r_beat_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_r_beat_gen
// Description : AXI R-channel beat generator. Queues per-burst read commands
//               (id, len, user), pairs each accepted single-word memory read
//               response with the burst at the queue head, and emits R beats
//               with RID, RRESP, RLAST and RUSER. Beats pass through a
//               2-entry output buffer, so every R output comes straight from
//               a register.
// Ports       :
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   cmd_valid_i/cmd_ready_o   burst command handshake
//   cmd_id_i/len_i/user_i     burst ID, AXI len (beats-1), user field
//   mem_rsp_valid_i/ready_o   memory read-word handshake
//   mem_rsp_data_i/err_i      read word and its error flag
//   r_valid_o/r_ready_i       R beat handshake
//   r_id_o/data_o/resp_o/last_o/user_o   R beat fields
// Revision    : 1.0 - initial release
// ============================================================================
module axi_r_beat_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ID_WIDTH-1:0]   cmd_id_i,
    input  logic [7:0]            cmd_len_i,
    input  logic [USER_WIDTH-1:0] cmd_user_i,
    input  logic                  mem_rsp_valid_i,
    output logic                  mem_rsp_ready_o,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
    input  logic                  mem_rsp_err_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    output logic [USER_WIDTH-1:0] r_user_o
);

    localparam int c_PTR_W  = $clog2(CMD_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_BEAT_W = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;

    localparam logic [c_CNT_W-1:0] c_CMD_FULL    = c_CNT_W'(CMD_DEPTH);
    localparam logic [1:0]         c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]         c_RESP_SLVERR = 2'b10;
    localparam logic [1:0]         c_OUT_FULL    = 2'd2;

    // Command queue storage (data only, no reset needed)
    logic [ID_WIDTH-1:0]   r_cmd_id_mem   [CMD_DEPTH];
    logic [7:0]            r_cmd_len_mem  [CMD_DEPTH];
    logic [USER_WIDTH-1:0] r_cmd_user_mem [CMD_DEPTH];

    logic [c_PTR_W-1:0]  r_wr_ptr_q,   w_wr_ptr_d;
    logic [c_PTR_W-1:0]  r_rd_ptr_q,   w_rd_ptr_d;
    logic [c_CNT_W-1:0]  r_cmd_cnt_q,  w_cmd_cnt_d;
    logic [7:0]          r_beat_cnt_q, w_beat_cnt_d;
    logic [1:0]          r_out_cnt_q,  w_out_cnt_d;
    logic [c_BEAT_W-1:0] r_slot0_q,    w_slot0_d;   // oldest beat, drives R
    logic [c_BEAT_W-1:0] r_slot1_q,    w_slot1_d;

    logic                w_cmd_full;
    logic                w_cmd_push;
    logic                w_cmd_pop;
    logic                w_mem_ready;
    logic                w_mem_fire;
    logic                w_r_pop;
    logic                w_beat_last;
    logic [1:0]          w_beat_resp;
    logic [c_BEAT_W-1:0] w_new_beat;

    // ------------------------------------------------------------------
    // Handshake terms. Readiness uses only registered counters, so no
    // combinational path exists from any valid input to any ready output.
    // ------------------------------------------------------------------
    assign w_cmd_full  = (r_cmd_cnt_q == c_CMD_FULL);
    assign w_cmd_push  = cmd_valid_i && !w_cmd_full;
    assign w_mem_ready = (r_cmd_cnt_q != '0) && (r_out_cnt_q != c_OUT_FULL);
    assign w_mem_fire  = mem_rsp_valid_i && w_mem_ready;
    assign w_r_pop     = (r_out_cnt_q != 2'd0) && r_ready_i;

    assign w_beat_last = (r_beat_cnt_q == r_cmd_len_mem[r_rd_ptr_q]);
    assign w_cmd_pop   = w_mem_fire && w_beat_last;
    assign w_beat_resp = mem_rsp_err_i ? c_RESP_SLVERR : c_RESP_OKAY;
    assign w_new_beat  = {r_cmd_id_mem[r_rd_ptr_q], mem_rsp_data_i, w_beat_resp,
                          w_beat_last, r_cmd_user_mem[r_rd_ptr_q]};

    // ------------------------------------------------------------------
    // Command queue and beat counter next state
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_cmd_cnt_d  = r_cmd_cnt_q;
        w_beat_cnt_d = r_beat_cnt_q;

        if (w_cmd_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_cmd_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end

        case ({w_cmd_push, w_cmd_pop})
            2'b10:   w_cmd_cnt_d = r_cmd_cnt_q + c_CNT_W'(1);
            2'b01:   w_cmd_cnt_d = r_cmd_cnt_q - c_CNT_W'(1);
            default: w_cmd_cnt_d = r_cmd_cnt_q;
        endcase

        // The counter restarts at each burst boundary, so len=255 reaches 255
        // on the final beat and never wraps inside a burst.
        if (w_mem_fire) begin
            w_beat_cnt_d = w_beat_last ? 8'd0 : (r_beat_cnt_q + 8'd1);
        end
    end

    // ------------------------------------------------------------------
    // Output buffer next state: slot0 is always the oldest entry.
    // ------------------------------------------------------------------
    always_comb begin
        w_slot0_d   = r_slot0_q;
        w_slot1_d   = r_slot1_q;
        w_out_cnt_d = r_out_cnt_q;

        case ({w_mem_fire, w_r_pop})
            2'b10: begin
                if (r_out_cnt_q == 2'd0) begin
                    w_slot0_d = w_new_beat;
                end else begin
                    w_slot1_d = w_new_beat;
                end
                w_out_cnt_d = r_out_cnt_q + 2'd1;
            end
            2'b01: begin
                w_slot0_d   = r_slot1_q;
                w_out_cnt_d = r_out_cnt_q - 2'd1;
            end
            2'b11: begin
                // Count unchanged; the new beat lands behind whatever stays.
                if (r_out_cnt_q == 2'd1) begin
                    w_slot0_d = w_new_beat;
                end else begin
                    w_slot0_d = r_slot1_q;
                    w_slot1_d = w_new_beat;
                end
            end
            default: begin
                w_out_cnt_d = r_out_cnt_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_cmd_push) begin
            r_cmd_id_mem[r_wr_ptr_q]   <= cmd_id_i;
            r_cmd_len_mem[r_wr_ptr_q]  <= cmd_len_i;
            r_cmd_user_mem[r_wr_ptr_q] <= cmd_user_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_cmd_cnt_q  <= '0;
            r_beat_cnt_q <= 8'd0;
            r_out_cnt_q  <= 2'd0;
            r_slot0_q    <= '0;
            r_slot1_q    <= '0;
        end else begin
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_cmd_cnt_q  <= w_cmd_cnt_d;
            r_beat_cnt_q <= w_beat_cnt_d;
            r_out_cnt_q  <= w_out_cnt_d;
            r_slot0_q    <= w_slot0_d;
            r_slot1_q    <= w_slot1_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready_o     = !w_cmd_full;
    assign mem_rsp_ready_o = w_mem_ready;
    assign r_valid_o       = (r_out_cnt_q != 2'd0);
    assign {r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o} = r_slot0_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_r_beat_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_r_beat_gen
// Description : Self-checking bench for axi_r_beat_gen. Accepted commands and
//               memory words are logged; the expected R stream is rebuilt from
//               those logs (each burst takes len+1 words in order) and
//               compared with the R beats actually handed over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_r_beat_gen;

    localparam int c_DW = 64;
    localparam int c_IW = 4;
    localparam int c_UW = 1;
    localparam int c_BW = c_IW + c_DW + 2 + 1 + c_UW;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            cmd_valid_i = 1'b0;
    logic            cmd_ready_o;
    logic [c_IW-1:0] cmd_id_i = '0;
    logic [7:0]      cmd_len_i = '0;
    logic [c_UW-1:0] cmd_user_i = '0;
    logic            mem_rsp_valid_i = 1'b0;
    logic            mem_rsp_ready_o;
    logic [c_DW-1:0] mem_rsp_data_i = '0;
    logic            mem_rsp_err_i = 1'b0;
    logic            r_valid_o;
    logic            r_ready_i = 1'b0;
    logic [c_IW-1:0] r_id_o;
    logic [c_DW-1:0] r_data_o;
    logic [1:0]      r_resp_o;
    logic            r_last_o;
    logic [c_UW-1:0] r_user_o;

    always #5 clk_i = ~clk_i;

    axi_r_beat_gen #(
        .DATA_WIDTH (c_DW),
        .ID_WIDTH   (c_IW),
        .USER_WIDTH (c_UW),
        .CMD_DEPTH  (4)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_id_i        (cmd_id_i),
        .cmd_len_i       (cmd_len_i),
        .cmd_user_i      (cmd_user_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_ready_o (mem_rsp_ready_o),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_err_i   (mem_rsp_err_i),
        .r_valid_o       (r_valid_o),
        .r_ready_i       (r_ready_i),
        .r_id_o          (r_id_o),
        .r_data_o        (r_data_o),
        .r_resp_o        (r_resp_o),
        .r_last_o        (r_last_o),
        .r_user_o        (r_user_o)
    );

    int checks = 0;
    int errors = 0;

    logic [c_IW+8+c_UW-1:0] cmd_acc[$];   // {id, len, user}
    logic [c_DW:0]          word_acc[$];  // {data, err}
    logic [c_BW-1:0]        obs[$];       // {id, data, resp, last, user}
    logic [c_BW-1:0]        expq[$];

    // Log every handshake of the coming edge, then advance one cycle.
    task automatic tick();
        @(negedge clk_i);
        if (cmd_valid_i && cmd_ready_o)
            cmd_acc.push_back({cmd_id_i, cmd_len_i, cmd_user_i});
        if (mem_rsp_valid_i && mem_rsp_ready_o)
            word_acc.push_back({mem_rsp_data_i, mem_rsp_err_i});
        if (r_valid_o && r_ready_i)
            obs.push_back({r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o});
        @(posedge clk_i);
        #1;
    endtask

    // Reference: bursts consume memory words strictly in order, len+1 each.
    function automatic void build_expected();
        int w = 0;
        expq.delete();
        foreach (cmd_acc[c]) begin
            logic [c_IW-1:0] id;
            logic [7:0]      len;
            logic [c_UW-1:0] u;
            {id, len, u} = cmd_acc[c];
            for (int b = 0; b <= int'(len); b++) begin
                if (w < word_acc.size()) begin
                    expq.push_back({id, word_acc[w][c_DW:1],
                                    word_acc[w][0] ? 2'b10 : 2'b00,
                                    (b == int'(len)), u});
                    w++;
                end
            end
        end
    endfunction

    task automatic do_reset();
        cmd_valid_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i = 1'b0;
        r_ready_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cmd_acc.delete();
        word_acc.delete();
        obs.delete();
    endtask

    task automatic push_cmd(input int id, input int len, input int user);
        cmd_valid_i = 1'b1;
        cmd_id_i = c_IW'(id);
        cmd_len_i = 8'(len);
        cmd_user_i = c_UW'(user);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        #1;
        checks++;
        if ({cmd_ready_o, mem_rsp_ready_o, r_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 100", {cmd_ready_o, mem_rsp_ready_o, r_valid_o});
        end
        checks++;
        if ({r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got %h required 0", {r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o});
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic test_single_beat();
        do_reset();
        cmd_valid_i = 1'b1;
        cmd_id_i = 4'd3;
        cmd_len_i = 8'd0;
        cmd_user_i = 1'b1;
        checks++;
        if (mem_rsp_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ready_before_cmd: got %b required 0", mem_rsp_ready_o);
        end
        tick();
        cmd_valid_i = 1'b0;
        checks++;
        if (mem_rsp_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_after_cmd: got %b required 1", mem_rsp_ready_o);
        end
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = 64'hA5A5_0000_0000_A5A5;
        mem_rsp_err_i = 1'b0;
        tick();
        mem_rsp_valid_i = 1'b0;
        checks++;
        if ({r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o} !==
            {1'b1, 4'd3, 64'hA5A5_0000_0000_A5A5, 2'b00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL single_beat: got v=%b id=%h d=%h resp=%b last=%b user=%b required v=1 id=3 d=a5a50000_0000a5a5 resp=00 last=1 user=1",
                     r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o);
        end
        checks++;
        if (mem_rsp_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ready_drop: got %b required 0", mem_rsp_ready_o);
        end
        r_ready_i = 1'b1;
        tick();
        checks++;
        if (r_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: r_valid got %b required 0", r_valid_o);
        end
    endtask

    task automatic test_burst_stall();
        do_reset();
        push_cmd(5, 3, 0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            mem_rsp_valid_i = (word_acc.size() < 4);
            mem_rsp_data_i = 64'h10 + 64'(word_acc.size());
            tick();
            if (cyc == 1) begin
                checks++;
                if (mem_rsp_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_backpressure: mem_rsp_ready got %b required 0", mem_rsp_ready_o);
                end
            end
        end
        checks++;
        if (word_acc.size() != 2 || r_valid_o !== 1'b1 || r_data_o !== 64'h10) begin
            errors++;
            $display("FAIL stall_hold: accepted %0d v=%b data=%h required 2 1 10",
                     word_acc.size(), r_valid_o, r_data_o);
        end
        r_ready_i = 1'b1;
        tick();
        checks++;
        if (mem_rsp_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready_return: got %b required 1", mem_rsp_ready_o);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            mem_rsp_valid_i = (word_acc.size() < 4);
            mem_rsp_data_i = 64'h10 + 64'(word_acc.size());
            tick();
        end
        mem_rsp_valid_i = 1'b0;
        build_expected();
        checks++;
        if (obs.size() != 4 || expq.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats required 4 (model %0d)", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL stall_beat[%0d]: got %h required %h", i, obs[i], expq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        r_ready_i = 1'b1;
        push_cmd(1, 1, 0);
        push_cmd(2, 0, 1);
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i = {$urandom, $urandom};
            tick();
        end
        mem_rsp_valid_i = 1'b0;
        checks++;
        if (word_acc.size() != 3) begin
            errors++;
            $display("FAIL b2b_accept: got %0d words in 3 cycles required 3", word_acc.size());
        end
        tick();
        checks++;
        if (obs.size() != 3) begin
            errors++;
            $display("FAIL b2b_consecutive: got %0d beats after 4 cycles required 3", obs.size());
        end
        build_expected();
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL b2b_beat[%0d]: got %h required %h", i, obs[i], expq[i]);
            end
        end
    endtask

    task automatic test_error_beat();
        do_reset();
        r_ready_i = 1'b1;
        push_cmd(7, 3, 1);
        for (int cyc = 0; cyc < 12; cyc++) begin
            mem_rsp_valid_i = (word_acc.size() < 4);
            mem_rsp_err_i = (word_acc.size() == 2);
            mem_rsp_data_i = {$urandom, $urandom};
            tick();
        end
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i = 1'b0;
        checks++;
        if (obs.size() != 4) begin
            errors++;
            $display("FAIL err_count: got %0d beats required 4", obs.size());
        end
        for (int i = 0; i < obs.size(); i++) begin
            logic [2:0] rl;
            rl = obs[i][c_UW +: 3];
            checks++;
            if (rl !== {(i == 2) ? 2'b10 : 2'b00, (i == 3)}) begin
                errors++;
                $display("FAIL err_resp_last[%0d]: got resp/last %b required %b", i, rl,
                         {(i == 2) ? 2'b10 : 2'b00, (i == 3)});
            end
        end
    endtask

    task automatic test_queue_full();
        do_reset();
        r_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL full_ready_before[%0d]: got %b required 1", i, cmd_ready_o);
            end
            push_cmd(8 + i, (i == 0) ? 1 : 0, i % 2);
        end
        checks++;
        if (cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_after4: got %b required 0", cmd_ready_o);
        end
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = 64'hF00D_0000;
        tick();
        checks++;
        if (cmd_ready_o !== 1'b0 || word_acc.size() != 1) begin
            errors++;
            $display("FAIL full_mid_burst: ready=%b words=%0d required 0 1", cmd_ready_o, word_acc.size());
        end
        mem_rsp_data_i = 64'hF00D_0001;
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1 || word_acc.size() != 2) begin
            errors++;
            $display("FAIL full_release: ready=%b words=%0d required 1 2", cmd_ready_o, word_acc.size());
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            mem_rsp_valid_i = (word_acc.size() < 5);
            mem_rsp_data_i = {$urandom, $urandom};
            tick();
        end
        mem_rsp_valid_i = 1'b0;
        build_expected();
        checks++;
        if (obs.size() != 5 || expq.size() != 5) begin
            errors++;
            $display("FAIL full_count: got %0d beats required 5 (model %0d)", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL full_beat[%0d]: got %h required %h", i, obs[i], expq[i]);
            end
        end
    endtask

    task automatic test_long_burst();
        int mism = 0;
        do_reset();
        push_cmd(6, 255, 1);
        for (int cyc = 0; cyc < 1500 && obs.size() < 256; cyc++) begin
            mem_rsp_valid_i = ($urandom_range(0, 3) != 0);
            mem_rsp_data_i = {$urandom, $urandom};
            mem_rsp_err_i = ($urandom_range(0, 15) == 0);
            r_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        mem_rsp_valid_i = 1'b1;
        r_ready_i = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) tick();
        mem_rsp_valid_i = 1'b0;
        checks++;
        if (word_acc.size() != 256 || obs.size() != 256) begin
            errors++;
            $display("FAIL long_count: words=%0d beats=%0d required 256 256", word_acc.size(), obs.size());
        end
        build_expected();
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            if (obs[i] !== expq[i]) begin
                if (mism == 0)
                    $display("FAIL long_beat[%0d]: got %h required %h", i, obs[i], expq[i]);
                mism++;
            end
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL long_beats: %0d mismatching beats required 0", mism);
        end
    endtask

    task automatic test_random();
        int total = 0;
        int mism = 0;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            cmd_valid_i = ($urandom_range(0, 2) == 0);
            cmd_id_i = c_IW'($urandom);
            cmd_len_i = 8'($urandom_range(0, 5));
            cmd_user_i = c_UW'($urandom);
            mem_rsp_valid_i = ($urandom_range(0, 1) == 0);
            mem_rsp_data_i = {$urandom, $urandom};
            mem_rsp_err_i = ($urandom_range(0, 7) == 0);
            r_ready_i = ($urandom_range(0, 1) == 0);
            tick();
        end
        cmd_valid_i = 1'b0;
        r_ready_i = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i = {$urandom, $urandom};
            mem_rsp_err_i = 1'b0;
            tick();
        end
        mem_rsp_valid_i = 1'b0;
        foreach (cmd_acc[c]) total += int'(cmd_acc[c][c_UW +: 8]) + 1;
        build_expected();
        checks++;
        if (obs.size() != total || expq.size() != total) begin
            errors++;
            $display("FAIL rand_count: got %0d beats required %0d (model %0d)", obs.size(), total, expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            if (obs[i] !== expq[i]) begin
                if (mism == 0)
                    $display("FAIL rand_beat[%0d]: got %h required %h", i, obs[i], expq[i]);
                mism++;
            end
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL rand_beats: %0d mismatching beats required 0", mism);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic seen = 1'b0;
        do_reset();
        r_ready_i = 1'b1;
        push_cmd(9, 7, 1);
        for (int cyc = 0; cyc < 10 && word_acc.size() < 3; cyc++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i = {$urandom, $urandom};
            tick();
        end
        checks++;
        if (r_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: r_valid got %b required 1", r_valid_o);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({cmd_ready_o, mem_rsp_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o} !==
            {1'b1, 1'b0, 1'b0, {c_BW{1'b0}}}) begin
            errors++;
            $display("FAIL rstmid_async: got cr=%b mr=%b v=%b fields=%h required 1 0 0 0",
                     cmd_ready_o, mem_rsp_ready_o, r_valid_o,
                     {r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o});
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        word_acc.delete();
        obs.delete();
        for (int cyc = 0; cyc < 8; cyc++) begin
            mem_rsp_valid_i = 1'b1;
            tick();
            if (r_valid_o || mem_rsp_ready_o) seen = 1'b1;
        end
        mem_rsp_valid_i = 1'b0;
        checks++;
        if (seen || word_acc.size() != 0) begin
            errors++;
            $display("FAIL rstmid_orphan: activity=%b words=%0d required 0 0", seen, word_acc.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst_stall();
        test_back_to_back();
        test_error_beat();
        test_queue_full();
        test_long_burst();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
